// File: rtl/led_effect_scheduler.sv
// ---------------------------------------------------------------------------
// led_effect_scheduler
//
// Purpose:
//   Steps a WIDTH-bit LED bank through four light effects in a fixed loop:
//   fill-then-clear, running dot, ping-pong and blink-all. One pattern step
//   is taken per tick strobe from the clock divider. Each effect plays for
//   PASSES complete passes before the scheduler moves on by itself, and a
//   next pulse skips straight to the following effect. The speed output
//   tells the divider which rate the current effect wants.
//
// Ports:
//   clk_i          system clock, all state changes on its rising edge
//   rst_ni         synchronous active-low reset
//   tick_i         one-cycle step strobe from the divider
//   next_i         one-cycle pulse, skip to the next effect
//   hold_i         level, 1 freezes stepping (next still acts)
//   q_o            LED pattern, bit 0 is the first LED
//   effect_o       current effect index (0..3)
//   speed_o        divider mode request, 1 = slow effects, 0 = fast effects
//   pass_done_o    one-cycle pulse in the cycle after a pass completes
// ---------------------------------------------------------------------------
module led_effect_scheduler #(
  parameter int WIDTH  = 8,
  parameter int PASSES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             next_i,
  input  logic             hold_i,
  output logic [WIDTH-1:0] q_o,
  output logic [1:0]       effect_o,
  output logic             speed_o,
  output logic             pass_done_o
);

  // Step counter must reach 2*WIDTH-1 (the longest effect); the pass
  // counter keeps at least one bit so PASSES=1 still has a legal register.
  localparam int STEP_W = $clog2(2 * WIDTH);
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  // Final step index of each effect, plus the constants the pattern decode
  // needs, all pre-sized to the step counter width.
  localparam logic [STEP_W-1:0] LAST_FILL  = STEP_W'(2 * WIDTH - 1);
  localparam logic [STEP_W-1:0] LAST_RUN   = STEP_W'(WIDTH - 1);
  localparam logic [STEP_W-1:0] LAST_PP    = STEP_W'(2 * WIDTH - 3);
  localparam logic [STEP_W-1:0] LAST_BLINK = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_WIDTH = STEP_W'(WIDTH);
  localparam logic [STEP_W-1:0] PP_MIRROR  = STEP_W'(2 * WIDTH - 2);
  localparam logic [PASS_W-1:0] PASS_LAST  = PASS_W'(PASSES - 1);
  localparam logic [PASS_W-1:0] PASS_ONE   = PASS_W'(1);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_HOT  = {{(WIDTH-1){1'b0}}, 1'b1};

  // The effect register is the scheduler's state machine: it walks the four
  // effects in order and wraps from BLINK back to FILL_CLEAR.
  typedef enum logic [1:0] {
    FILL_CLEAR = 2'd0,
    RUN_DOT    = 2'd1,
    PING_PONG  = 2'd2,
    BLINK      = 2'd3
  } effect_e;

  effect_e             effect_q, effect_d;
  logic [STEP_W-1:0]   step_q,   step_d;
  logic [PASS_W-1:0]   pass_q,   pass_d;
  logic                pass_done_q, pass_done_d;

  effect_e             effectNext;
  logic [STEP_W-1:0]   lastStep;
  logic [WIDTH-1:0]    ledPattern;

  // The effect after the current one; two-bit arithmetic makes BLINK wrap
  // back to FILL_CLEAR without any special case.
  assign effectNext = effect_e'(effect_q + 2'd1);

  // Length of the current effect, expressed as the index of its final step.
  // This is the point where a tick completes a pass instead of stepping on.
  always_comb begin
    lastStep = LAST_FILL;
    case (effect_q)
      FILL_CLEAR: lastStep = LAST_FILL;
      RUN_DOT:    lastStep = LAST_RUN;
      PING_PONG:  lastStep = LAST_PP;
      BLINK:      lastStep = LAST_BLINK;
      default:    lastStep = LAST_FILL;
    endcase
  end

  // All scheduler state lives here. Reset is synchronous, so a low rst_ni
  // only takes effect on a clock edge, and it overrides every other input.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      effect_q    <= FILL_CLEAR;
      step_q      <= '0;
      pass_q      <= '0;
      pass_done_q <= 1'b0;
    end else begin
      effect_q    <= effect_d;
      step_q      <= step_d;
      pass_q      <= pass_d;
      pass_done_q <= pass_done_d;
    end
  end

  // Next-state logic, in priority order. A skip request beats both hold and
  // a coincident tick and throws away any partial pass. Hold freezes the
  // sequence. Otherwise each tick advances one step; the tick that lands on
  // the final step wraps the step, flags the completed pass, and moves to
  // the next effect once the last pass of this effect has finished. The
  // pass-done flag defaults low so it only ever lasts a single cycle.
  always_comb begin
    effect_d    = effect_q;
    step_d      = step_q;
    pass_d      = pass_q;
    pass_done_d = 1'b0;

    if (next_i) begin
      effect_d = effectNext;
      step_d   = '0;
      pass_d   = '0;
    end else if (hold_i) begin
      effect_d = effect_q;
    end else if (tick_i) begin
      if (step_q < lastStep) begin
        step_d = step_q + STEP_ONE;
      end else begin
        step_d      = '0;
        pass_done_d = 1'b1;
        if (pass_q >= PASS_LAST) begin
          pass_d   = '0;
          effect_d = effectNext;
        end else begin
          pass_d = pass_q + PASS_ONE;
        end
      end
    end
  end

  // Pattern decode straight from the registers, so the LEDs change on the
  // same edge that moves the step. Fill-clear builds a bar of ones from the
  // bottom and then shifts it out of the top; ping-pong mirrors the step
  // index back down once it has passed the top LED. Any step beyond the
  // effect's final step cannot occur but is forced dark for safety.
  always_comb begin
    ledPattern = '0;
    case (effect_q)
      FILL_CLEAR: begin
        if (step_q < STEP_WIDTH) begin
          ledPattern = ALL_ONES >> (STEP_WIDTH - STEP_ONE - step_q);
        end else begin
          ledPattern = ALL_ONES << (step_q - STEP_WIDTH + STEP_ONE);
        end
      end
      RUN_DOT: begin
        ledPattern = ONE_HOT << step_q;
      end
      PING_PONG: begin
        if (step_q < STEP_WIDTH) begin
          ledPattern = ONE_HOT << step_q;
        end else begin
          ledPattern = ONE_HOT << (PP_MIRROR - step_q);
        end
      end
      BLINK: begin
        ledPattern = (step_q == '0) ? ALL_ONES : '0;
      end
      default: ledPattern = '0;
    endcase

    if (step_q > lastStep) begin
      ledPattern = '0;
    end
  end

  // The bar and blink effects are meant to be watched slowly; the moving
  // dot effects ask the divider for its faster rate.
  assign speed_o     = (effect_q == FILL_CLEAR) || (effect_q == BLINK);
  assign q_o         = ledPattern;
  assign effect_o    = effect_q;
  assign pass_done_o = pass_done_q;

endmodule

// File: tb/tb_led_effect_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_effect_scheduler
//
// Purpose:
//   Directed self-checking bench for led_effect_scheduler (WIDTH=8,
//   PASSES=2). The driver applies one input vector per cycle and queues the
//   hand-computed outputs expected after that edge; a separate monitor pops
//   one entry per cycle shortly after the rising edge and compares.
// ---------------------------------------------------------------------------
module tb_led_effect_scheduler;

  localparam int WIDTH  = 8;
  localparam int PASSES = 2;

  logic             clk;
  logic             rstN;
  logic             tick;
  logic             nextPulse;
  logic             hold;
  logic [WIDTH-1:0] qOut;
  logic [1:0]       effectOut;
  logic             speedOut;
  logic             passDoneOut;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic [1:0] eff;
    logic       spd;
    logic       pd;
  } expect_t;

  expect_t    scoreboard[$];
  expect_t    monExp;
  int         errors = 0;
  int         checks = 0;
  int         vecId  = 0;

  logic [7:0] fillSeq  [16];
  logic [7:0] runSeq   [8];
  logic [7:0] ppSeq    [14];
  logic [7:0] blinkSeq [4];
  logic [1:0] blinkEff [4];
  logic       blinkPd  [4];

  led_effect_scheduler #(
    .WIDTH (WIDTH),
    .PASSES(PASSES)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .tick_i     (tick),
    .next_i     (nextPulse),
    .hold_i     (hold),
    .q_o        (qOut),
    .effect_o   (effectOut),
    .speed_o    (speedOut),
    .pass_done_o(passDoneOut)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slow effects are FILL_CLEAR (0) and BLINK (3).
  function automatic logic speedFor(input logic [1:0] e);
    return (e == 2'd0) || (e == 2'd3);
  endfunction

  // Drive one vector at the falling edge and queue what the outputs must
  // look like after the following rising edge.
  task automatic applyStimulus(input logic rV, input logic tV, input logic nV,
                               input logic hV, input logic [7:0] expQ,
                               input logic [1:0] expEff, input logic expPd);
    expect_t e;
    @(negedge clk);
    rstN      = rV;
    tick      = tV;
    nextPulse = nV;
    hold      = hV;
    e.id  = vecId;
    e.q   = expQ;
    e.eff = expEff;
    e.spd = speedFor(expEff);
    e.pd  = expPd;
    scoreboard.push_back(e);
    vecId++;
  endtask

  // Compare all four outputs against one queued expectation.
  task automatic checkOutput(input expect_t e);
    checks++;
    if (qOut !== e.q) begin
      errors++;
      $display("[TB] FAIL q vec=%0d got=%h exp=%h", e.id, qOut, e.q);
    end
    checks++;
    if (effectOut !== e.eff) begin
      errors++;
      $display("[TB] FAIL effect vec=%0d got=%0d exp=%0d", e.id, effectOut, e.eff);
    end
    checks++;
    if (speedOut !== e.spd) begin
      errors++;
      $display("[TB] FAIL speed vec=%0d got=%b exp=%b", e.id, speedOut, e.spd);
    end
    checks++;
    if (passDoneOut !== e.pd) begin
      errors++;
      $display("[TB] FAIL pass_done vec=%0d got=%b exp=%b", e.id, passDoneOut, e.pd);
    end
  endtask

  // Monitor: one expectation is consumed per rising edge, sampled 1 ns
  // after the edge so the registered outputs have settled.
  always begin
    @(posedge clk);
    #1;
    if (scoreboard.size() != 0) begin
      monExp = scoreboard.pop_front();
      checkOutput(monExp);
    end
  end

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN      = 1'b0;
    tick      = 1'b0;
    nextPulse = 1'b0;
    hold      = 1'b0;
    fillSeq  = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
    runSeq   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    ppSeq    = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    blinkSeq = '{8'h00, 8'hFF, 8'h00, 8'h01};
    blinkEff = '{2'd3, 2'd3, 2'd3, 2'd0};
    blinkPd  = '{1'b0, 1'b1, 1'b0, 1'b1};

    $display("[TB] start");

    // Reset held, then released with no tick: idle reset state.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 2'd0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 2'd0, 1'b0);

    // First FILL_CLEAR pass: one pass-done pulse, effect stays 0.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, fillSeq[i], 2'd0, (i == 15));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 2'd0, 1'b0);

    // Second pass completes the effect and advances to RUN_DOT.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, fillSeq[i],
                    (i == 15) ? 2'd1 : 2'd0, (i == 15));

    // RUN_DOT: two passes, the second one advances to PING_PONG.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, runSeq[i], 2'd1, (i == 7));
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, runSeq[i],
                    (i == 7) ? 2'd2 : 2'd1, (i == 7));

    // PING_PONG to step 3, then NEXT and TICK together.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, runSeq[i], 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 2'd3, 1'b0);

    // Hold freezes BLINK against ticks; NEXT still acts while held.
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 2'd3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 2'd0, 1'b0);

    // Skip forward to PING_PONG and run a full pass including the turn.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 2'd2, 1'b0);
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, ppSeq[i], 2'd2, (i == 13));

    // Skip into BLINK (discarding the pass count), two full passes wrap to 0.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, blinkSeq[i], blinkEff[i], blinkPd[i]);

    // FILL_CLEAR pass 0 complete, then into pass 1 up to step 9.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, fillSeq[i], 2'd0, (i == 15));
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, fillSeq[i], 2'd0, 1'b0);

    // Reset wins over tick and next; afterwards a full pass without advance.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 2'd0, 1'b0);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, fillSeq[i], 2'd0, (i == 15));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 2'd0, 1'b0);

    // Let the monitor drain the queue, then confirm nothing is left over.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got=%0d exp=0 entries left", scoreboard.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
